axi_rd_arbiter: RTL

- Round-robin arbiter that shares one AXI4-Lite read channel (AR/R) among N_MST requesters: IFU, LSU and a spare debug/DMA port.
- Sits between the requesters and the XBAR read port. The write channel stays on the existing LSU-only path.
- Exactly one read is outstanding at a time.
- A watchdog returns SLVERR to the granted master when the slave stalls.

---
 rtl/axi_rd_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI4-Lite read-channel arbiter with one outstanding read
// and a watchdog that answers SLVERR when the slave stalls.
module axi_rd_arbiter #(
    parameter int N_MST   = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_MST-1:0]         m_arvalid,
    input  logic [N_MST*AW-1:0]      m_araddr,
    output logic [N_MST-1:0]         m_arready,
    output logic [N_MST-1:0]         m_rvalid,
    input  logic [N_MST-1:0]         m_rready,
    output logic [DW-1:0]            m_rdata,
    output logic [1:0]               m_rresp,
    output logic                     s_arvalid,
    output logic [AW-1:0]            s_araddr,
    input  logic                     s_arready,
    input  logic                     s_rvalid,
    output logic                     s_rready,
    input  logic [DW-1:0]            s_rdata,
    input  logic [1:0]               s_rresp,
    output logic [$clog2(N_MST)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int GW = $clog2(N_MST);
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [15:0] CNT_LAST = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_ERR, S_DRAIN
    } state_e;

    state_e         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           terr_q, terr_d;
    logic           err_data_q, err_data_d;

    logic [GW-1:0]    win;
    logic [GW-1:0]    g_next;
    logic             any_req;
    logic [N_MST-1:0] g_oh;
    logic             g_arvalid;
    logic             g_rready;
    logic [AW-1:0]    g_araddr;
    logic             ar_hs;
    logic             r_hs;
    logic             expire;

    always_comb begin
        g_oh      = '0;
        g_arvalid = 1'b0;
        g_rready  = 1'b0;
        g_araddr  = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (grant_q == GW'(i)) begin
                g_oh[i]   = 1'b1;
                g_arvalid = m_arvalid[i];
                g_rready  = m_rready[i];
                g_araddr  = m_araddr[i*AW +: AW];
            end
        end
    end

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        any_req = 1'b0;
        win     = rr_ptr_q;
        for (int k = 0; k < N_MST; k++) begin
            if (!any_req && m_arvalid[(int'(rr_ptr_q) + k) % N_MST]) begin
                any_req = 1'b1;
                win     = GW'((int'(rr_ptr_q) + k) % N_MST);
            end
        end
    end

    assign g_next = (grant_q == GW'(N_MST - 1)) ? '0 : grant_q + GW'(1);
    assign ar_hs  = g_arvalid & s_arready;
    assign r_hs   = s_rvalid & g_rready;
    assign expire = WD_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            terr_q     <= 1'b0;
            err_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            terr_q     <= terr_d;
            err_data_q <= err_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        terr_d     = terr_q;
        err_data_d = err_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d = win;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ar_hs) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else if (expire) begin
                    terr_d     = 1'b1;
                    err_data_d = 1'b0;
                    state_d    = S_ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    rr_ptr_d = g_next;
                    state_d  = S_IDLE;
                end else if (expire) begin
                    terr_d     = 1'b1;
                    err_data_d = 1'b1;
                    state_d    = S_ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ERR: begin
                if (g_rready) begin
                    rr_ptr_d = g_next;
                    state_d  = err_data_q ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (s_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_rready  = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            busy = (state_q != S_IDLE);
            unique case (state_q)
                S_IDLE: ;
                S_ADDR: begin
                    s_arvalid = g_arvalid;
                    s_araddr  = g_araddr;
                    m_arready = g_oh & {N_MST{s_arready}};
                end
                S_DATA: begin
                    m_rvalid = g_oh & {N_MST{s_rvalid}};
                    m_rdata  = s_rdata;
                    m_rresp  = s_rresp;
                    s_rready = g_rready;
                end
                S_ERR: begin
                    m_rvalid = g_oh;
                    m_rresp  = 2'b10;
                end
                S_DRAIN: s_rready = 1'b1;
                default: ;
            endcase
        end
    end

    assign grant_id    = grant_q;
    assign timeout_err = terr_q;

endmodule
